// File: rtl/fsm_step_seq_if.sv
// fsm_step_seq bus: start/abort/delay and FSM state in, FSM drive and status out.
// master = requester/testbench side, slave = the sequencer.
interface fsm_step_seq_if #(
    parameter int SIZE    = 3,
    parameter int DELAY_W = 8
);
    logic               start_i;
    logic               abort_i;
    logic [DELAY_W-1:0] delay_i;
    logic [SIZE-1:0]    state_i;
    logic               enable_o;
    logic               fsm_reset_o;
    logic               busy_o;
    logic               done_o;
    logic               error_o;

    modport master (
        output start_i, abort_i, delay_i, state_i,
        input  enable_o, fsm_reset_o, busy_o, done_o, error_o
    );

    modport slave (
        input  start_i, abort_i, delay_i, state_i,
        output enable_o, fsm_reset_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/fsm_step_seq.sv
// fsm_step_seq: steps an IDLE/INIT/STRT one-hot FSM with a programmable
// inter-step delay and confirms each transition against its state vector.
// Ports: clock_i, reset_n_i (async, active-low), bus (fsm_step_seq_if.slave):
//   start_i, abort_i, delay_i, state_i in; enable_o, fsm_reset_o, busy_o,
//   done_o, error_o out (all registered).
// Option: define FSM_STEP_SEQ_TIMEOUT_EN to add the CHECK timeout counter.
module fsm_step_seq #(
    parameter int SIZE    = 3,
    parameter int DELAY_W = 8,
    parameter int TIMEOUT = 16
) (
    input logic             clock_i,
    input logic             reset_n_i,
    fsm_step_seq_if.slave   bus
);
    localparam logic [SIZE-1:0] ST_IDLE = SIZE'(1);
    localparam logic [SIZE-1:0] ST_INIT = SIZE'(2);
    localparam logic [SIZE-1:0] ST_STRT = SIZE'(4);

    typedef enum logic [2:0] {
        S_ABORT,
        S_IDLE,
        S_WAIT,
        S_STEP,
        S_CHECK,
        S_DONE,
        S_ERR
    } st_t;

    st_t                state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]    exp_q, exp_d;
    logic               en_q, rst_q, busy_q, done_q, err_q;

`ifdef FSM_STEP_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    to_q, to_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
`ifdef FSM_STEP_SEQ_TIMEOUT_EN
        to_d    = to_q;
`endif
        if (bus.abort_i) begin
            state_d = S_ABORT;
        end else begin
            unique case (state_q)
                S_ABORT: state_d = S_IDLE;
                S_IDLE: begin
                    if (bus.start_i) begin
                        // X or multi-hot state_i fails the compare -> ERR
                        if (bus.state_i == ST_IDLE) begin
                            state_d = S_WAIT;
                            cnt_d   = bus.delay_i;
                            exp_d   = ST_INIT;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) state_d = S_STEP;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_STEP: begin
                    state_d = S_CHECK;
`ifdef FSM_STEP_SEQ_TIMEOUT_EN
                    to_d    = TO_W'(TIMEOUT);
`endif
                end
                S_CHECK: begin
                    if (bus.state_i == exp_q) begin
                        if (exp_q == ST_STRT) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WAIT;
                            exp_d   = ST_STRT;
                            cnt_d   = bus.delay_i;
                        end
                    end
`ifdef FSM_STEP_SEQ_TIMEOUT_EN
                    else if (to_q == '0) state_d = S_ERR;
                    else                 to_d    = to_q - 1'b1;
`endif
                end
                S_DONE: begin
                    if (bus.state_i != ST_STRT) state_d = S_ABORT;
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_ABORT;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_ABORT;
            cnt_q   <= '0;
            exp_q   <= ST_INIT;
`ifdef FSM_STEP_SEQ_TIMEOUT_EN
            to_q    <= '0;
`endif
            en_q    <= 1'b0;
            rst_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
`ifdef FSM_STEP_SEQ_TIMEOUT_EN
            to_q    <= to_d;
`endif
            // outputs registered from the next state: pure Moore decode
            en_q    <= (state_d == S_STEP);
            rst_q   <= (state_d == S_ABORT);
            busy_q  <= (state_d == S_ABORT) || (state_d == S_WAIT) ||
                       (state_d == S_STEP)  || (state_d == S_CHECK);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign bus.enable_o    = en_q;
    assign bus.fsm_reset_o = rst_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.error_o     = err_q;
endmodule

// File: tb/tb_fsm_step_seq.sv
// Testbench for fsm_step_seq: attached IDLE/INIT/STRT model, scoreboard of
// expected enable/done/error events with cycle stamps, directed + random runs.
module tb_fsm_step_seq;
    localparam int SIZE    = 3;
    localparam int DELAY_W = 8;
    localparam int TIMEOUT = 16;

    localparam int EV_EN   = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    ev_t  q[$];

    logic [2:0] fst;
    logic       stuck;
    logic       force_en;
    logic [2:0] force_val;
    logic       prev_done;
    logic       prev_err;

    fsm_step_seq_if #(.SIZE(SIZE), .DELAY_W(DELAY_W)) bus ();

    fsm_step_seq #(
        .SIZE(SIZE),
        .DELAY_W(DELAY_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_i(clk),
        .reset_n_i(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controlled FSM: resets on fsm_reset, advances one state per enable.
    always @(posedge clk) begin
        if (bus.fsm_reset_o) fst <= 3'b001;
        else if (bus.enable_o && !stuck) begin
            if (fst == 3'b001)      fst <= 3'b010;
            else if (fst == 3'b010) fst <= 3'b100;
        end
    end

    assign bus.state_i = force_en ? force_val : fst;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ev(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d",
                     kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    task automatic push(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic do_abort();
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_fsm_reset", bus.fsm_reset_o, 1'b1);
        @(negedge clk);
        chk("idle_after_abort",
            {bus.fsm_reset_o, bus.busy_o, bus.done_o, bus.error_o}, 4'b0);
        chk("fsm_idle_after_abort", bus.state_i, 3'b001);
    endtask

    // Normal run: timing derived from the stepping rules:
    // WAIT d+1, STEP 1, CHECK 1 per step; done after the second CHECK.
    task automatic run_txn(input int d);
        int k;
        @(negedge clk);
        bus.delay_i = DELAY_W'(d);
        bus.start_i = 1'b1;
        k = cyc + 1;
        push(EV_EN, k + d + 1);
        push(EV_EN, k + 2 * d + 4);
        push(EV_DONE, k + 2 * d + 6);
        @(negedge clk);
        bus.start_i = 1'b0;
        while (cyc < k + 2 * d + 6) @(negedge clk);
        chk("done_held", bus.done_o, 1'b1);
        chk("fsm_strt", bus.state_i, 3'b100);
        do_abort();
    endtask

    initial begin
        int k;
        cyc = 0;
        errors = 0;
        checks = 0;
        stuck = 1'b0;
        force_en = 1'b0;
        force_val = 3'b000;
        fst = 3'b000;
        prev_done = 1'b0;
        prev_err = 1'b0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.delay_i = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_done = 1'b0;
                    prev_err  = 1'b0;
                end else begin
                    if (bus.enable_o) ev(EV_EN);
                    if (bus.done_o && !prev_done) ev(EV_DONE);
                    if (bus.error_o && !prev_err) ev(EV_ERR);
                    prev_done = bus.done_o;
                    prev_err  = bus.error_o;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.enable_o, bus.fsm_reset_o, bus.busy_o,
             bus.done_o, bus.error_o}, 5'b01100);
        rst_n = 1'b1;
        #1;
        chk("fsm_reset_after_release", bus.fsm_reset_o, 1'b1);
        @(negedge clk);
        chk("idle_after_release",
            {bus.enable_o, bus.fsm_reset_o, bus.busy_o,
             bus.done_o, bus.error_o}, 5'b0);
        chk("fsm_state_reset", bus.state_i, 3'b001);

        run_txn(3);
        run_txn(0);
        for (int i = 0; i < 10; i++) run_txn($urandom_range(0, 12));
        run_txn(40);

        // bad start state
        force_en = 1'b1;
        force_val = 3'b010;
        @(negedge clk);
        bus.start_i = 1'b1;
        k = cyc + 1;
        push(EV_ERR, k);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("bad_start_error", bus.error_o, 1'b1);
        repeat (4) @(negedge clk);
        chk("error_held", bus.error_o, 1'b1);
        force_en = 1'b0;
        do_abort();

        // abort beats start in IDLE
        @(negedge clk);
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        chk("abort_wins",
            {bus.fsm_reset_o, bus.busy_o, bus.enable_o}, 3'b110);
        @(negedge clk);
        chk("idle_after_abort_start", bus.busy_o, 1'b0);

        // abort during WAIT: no enable may follow
        @(negedge clk);
        bus.delay_i = 8'd10;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("busy_in_wait", bus.busy_o, 1'b1);
        repeat (2) @(negedge clk);
        do_abort();
        repeat (25) @(negedge clk);

        // FSM ignores enable
        stuck = 1'b1;
        @(negedge clk);
        bus.delay_i = 8'd2;
        bus.start_i = 1'b1;
        k = cyc + 1;
        push(EV_EN, k + 3);
`ifdef FSM_STEP_SEQ_TIMEOUT_EN
        push(EV_ERR, k + 2 + TIMEOUT + 3);
`endif
        @(negedge clk);
        bus.start_i = 1'b0;
`ifdef FSM_STEP_SEQ_TIMEOUT_EN
        while (cyc < k + 2 + TIMEOUT + 3) @(negedge clk);
        chk("timeout_error", {bus.busy_o, bus.error_o}, 2'b01);
`else
        repeat (100) @(negedge clk);
        chk("no_timeout", {bus.busy_o, bus.error_o}, 2'b10);
`endif
        stuck = 1'b0;
        do_abort();

        // async reset while enable_o is high
        @(negedge clk);
        bus.delay_i = 8'd2;
        bus.start_i = 1'b1;
        k = cyc + 1;
        push(EV_EN, k + 3);
        @(negedge clk);
        bus.start_i = 1'b0;
        while (cyc < k + 3) @(negedge clk);
        chk("enable_before_reset", bus.enable_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("enable_cut_by_reset",
            {bus.enable_o, bus.fsm_reset_o, bus.busy_o}, 3'b011);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_async_reset", bus.busy_o, 1'b0);
        chk("fsm_after_async_reset", bus.state_i, 3'b001);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
